fetch_stage: RTL and testbench

Instruction-fetch stage of the RV32I pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter and drives the synchronous-read instruction BRAM. It emits the `if_id_t` payload, which the IF/ID register captures on the same edge the BRAM registers the instruction, so `pc` and instruction arrive in ID aligned. It handles stall, EX redirect and, optionally, a static BTFN branch predictor evaluated on the instruction currently in ID.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/btfn_predictor.sv | 37 +++
 rtl/fetch_stage.sv | 83 ++++++++
 tb/tb_fetch_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: IF/ID payload and the opcode constants used by fetch.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  localparam logic [6:0]      OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]      OPC_JAL    = 7'b1101111;
  localparam logic [XLEN-1:0] INSTR_NOP  = 32'h0000_0013;

endpackage

// File: rtl/btfn_predictor.sv
// Static backward-taken/forward-not-taken guess for the instruction in ID.
// Purely combinational; used by fetch_stage only when FETCH_BTFN_EN is defined.
module btfn_predictor
  import riscv_pkg::*;
(
  input  logic [31:0] instr_id,
  input  logic [31:0] pc,
  output logic        taken_guess,
  output logic [31:0] target
);

  logic [6:0]  opcode;
  logic [12:0] imm_b;
  logic [20:0] imm_j;
  logic        is_branch;
  logic        is_jal;

  assign opcode    = instr_id[6:0];
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);

  assign imm_b = {instr_id[31], instr_id[7], instr_id[30:25], instr_id[11:8], 1'b0};
  assign imm_j = {instr_id[31], instr_id[19:12], instr_id[20], instr_id[30:21], 1'b0};

  // Sign bit of the immediate is instr[31] for both formats: set means a backward branch.
  always_comb begin
    taken_guess = 1'b0;
    target      = pc + {{19{imm_b[12]}}, imm_b};
    if (is_jal) begin
      taken_guess = 1'b1;
      target      = pc + {{11{imm_j[20]}}, imm_j};
    end else if (is_branch) begin
      taken_guess = instr_id[31];
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC and drives the synchronous-read BRAM.
// Define FETCH_BTFN_EN to enable the static BTFN predictor on the instruction in ID.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic [31:0]        instr_id,
  input  if_id_t             id_q,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  output if_id_t             d,
  output logic               pred_taken_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic        predict;

`ifdef FETCH_BTFN_EN
  logic        taken_guess;
  logic [31:0] target;
  logic        unused_id;

  btfn_predictor u_btfn (
    .instr_id    (instr_id),
    .pc          (id_q.pc),
    .taken_guess (taken_guess),
    .target      (target)
  );

  // Firing makes the next ID entry a bubble, so this cannot repeat on one instruction.
  assign predict   = id_q.valid && !stall && !redirect_valid && taken_guess;
  assign unused_id = ^id_q.pc_plus4;
`else
  logic [31:0] target;
  logic        unused_id;

  assign predict   = 1'b0;
  assign target    = pc_plus4;
  assign unused_id = ^{instr_id, id_q};
`endif

  assign pc_plus4     = pc_q + 32'd4;
  assign imem_addr    = pc_q[IMEM_AW+1:2];
  assign imem_en      = !stall && !rst;
  assign pred_taken_o = predict;

  always_comb begin
    d          = '0;
    d.pc       = pc_q;
    d.pc_plus4 = pc_plus4;
    d.valid    = !rst && !redirect_valid && !predict;
  end

  // Redirect beats stall; stall beats prediction.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end else if (predict) begin
      pc_d = target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; predictor checks follow FETCH_BTFN_EN.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam int unsigned IMEM_AW = 12;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic [31:0]        instr_id;
  if_id_t             id_q;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_en;
  if_id_t             d;
  logic               pred_taken_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] BEQ_BACK16 = 32'hFE00_08E3;
  localparam logic [31:0] BEQ_FWD16  = 32'h0000_0863;

  fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(IMEM_AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_id       (instr_id),
    .id_q           (id_q),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .d              (d),
    .pred_taken_o   (pred_taken_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] pc, input logic valid);
    check({tag, ".pc"}, d.pc, pc);
    check({tag, ".valid"}, 32'(d.valid), 32'(valid));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_id = INSTR_NOP; id_q = '0;
    #2;
    check("rst.pc", d.pc, 32'h0);
    check("rst.pc_plus4", d.pc_plus4, 32'h4);
    check("rst.valid", 32'(d.valid), 32'h0);
    check("rst.imem_en", 32'(imem_en), 32'h0);
    check("rst.imem_addr", 32'(imem_addr), 32'h0);
    check("rst.pred", 32'(pred_taken_o), 32'h0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    // Sequential fetch from RESET_PC
    for (int i = 0; i < 4; i++) begin
      check_fetch($sformatf("seq%0d", i), 32'(4 * i), 1'b1);
      check($sformatf("seq%0d.addr", i), 32'(imem_addr), 32'(i));
      check($sformatf("seq%0d.en", i), 32'(imem_en), 32'h1);
      tick();
    end

    // Stall holds pc at 0x10 for three cycles
    check_fetch("pre_stall", 32'h10, 1'b1);
    stall = 1'b1;
    #1;
    check("stall.en", 32'(imem_en), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d.pc", i), d.pc, 32'h10);
    end
    stall = 1'b0;
    tick();
    check_fetch("post_stall", 32'h14, 1'b1);

    // Redirect overrides stall; low bits of target ignored
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103;
    #1;
    check("redir.valid", 32'(d.valid), 32'h0);
    check("redir.en", 32'(imem_en), 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("redir_stall.pc", d.pc, 32'h100);
    check("redir_stall.en", 32'(imem_en), 32'h0);
    stall = 1'b0;
    #1;
    check_fetch("redir_go", 32'h100, 1'b1);
    check("redir_go.en", 32'(imem_en), 32'h1);
    tick();
    check_fetch("redir_next", 32'h104, 1'b1);

    // PC wraps at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("wrap.pc", d.pc, 32'hFFFF_FFFC);
    check("wrap.pc_plus4", d.pc_plus4, 32'h0);
    tick();
    check_fetch("wrap.next", 32'h0, 1'b1);

    // Backward / forward BEQ in ID at pc 0x40 (pc_q now 0x4)
    tick();
    check("pred_setup.pc", d.pc, 32'h4);
    id_q = '{pc: 32'h40, pc_plus4: 32'h44, valid: 1'b1};
    instr_id = BEQ_FWD16;
    #1;
    check("fwd.pred", 32'(pred_taken_o), 32'h0);
    check("fwd.valid", 32'(d.valid), 32'h1);
    instr_id = BEQ_BACK16;
    stall = 1'b1;
    #1;
    check("back_stall.pred", 32'(pred_taken_o), 32'h0);
    stall = 1'b0;
    #1;
`ifdef FETCH_BTFN_EN
    check("back.pred", 32'(pred_taken_o), 32'h1);
    check("back.valid", 32'(d.valid), 32'h0);
    tick();
    id_q.valid = 1'b0;
    #1;
    check_fetch("back.target", 32'h30, 1'b1);
    check("back.pred_after", 32'(pred_taken_o), 32'h0);
`else
    check("back.pred", 32'(pred_taken_o), 32'h0);
    check("back.valid", 32'(d.valid), 32'h1);
    tick();
    id_q.valid = 1'b0;
    #1;
    check_fetch("back.next", 32'h8, 1'b1);
`endif
    instr_id = INSTR_NOP;

    // Async reset mid-stream at pc 0x80
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_fetch("pre_arst", 32'h80, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_fetch("arst", 32'h0, 1'b0);
    check("arst.en", 32'(imem_en), 32'h0);
    tick();
    check_fetch("arst_hold", 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    check_fetch("arst_rel", 32'h0, 1'b1);
    tick();
    check_fetch("arst_next", 32'h4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
